// File: rtl/lbm_pkg.sv
// Shared lattice-Boltzmann definitions: word geometry,
// stage count, stage selector and distributor state types.
package lbm_pkg;

    localparam int LBM_DIRS       = 9;
    localparam int LBM_NX         = 16;
    localparam int LBM_NY         = 16;
    localparam int LBM_WB         = 16;
    localparam int LBM_WORD_W     = LBM_DIRS * LBM_NX * LBM_NY * LBM_WB;
    localparam int LBM_NUM_STAGES = 11;

    typedef logic [3:0] stage_sel_t;

    typedef enum logic {
        DIST_IDLE,
        DIST_HOLD
    } dist_state_t;

    // Legal stage indices are 0..LBM_NUM_STAGES-1.
    function automatic logic sel_legal(input stage_sel_t s);
        return (s < stage_sel_t'(LBM_NUM_STAGES));
    endfunction

endpackage

// File: rtl/lbm_dest_seq.sv
// Mod-11 destination counter for auto-sequenced distribution,
// with a registered pulse when the last stage's delivery completes.
module lbm_dest_seq
    import lbm_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       adv_i,
    input  logic       wrap_ev_i,
    output stage_sel_t dest_o,
    output logic       wrap_o
);

    stage_sel_t cnt_q;
    stage_sel_t cnt_d;
    logic       wrap_q;

    // Next destination: step on each accept, wrap after the last stage.
    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            if (cnt_q == stage_sel_t'(LBM_NUM_STAGES - 1))
                cnt_d = '0;
            else
                cnt_d = cnt_q + stage_sel_t'(1);
        end
    end

    // Counter and wrap-pulse registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_ev_i;
        end
    end

    assign dest_o = cnt_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/demux11_dist.sv
// Registered 1-to-11 lattice word distributor with hold-until-ack.
// Option: DEMUX11_AUTOSEQ_EN sequences destinations 0..10 internally.
module demux11_dist
    import lbm_pkg::*;
#(
    parameter int DATA_WIDTH = LBM_WORD_W,
    parameter int CNT_W      = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic signed [DATA_WIDTH-1:0] Din,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  stage_sel_t                   select,
    output logic signed [DATA_WIDTH-1:0] Dout,
    output logic [LBM_NUM_STAGES-1:0]    dout_valid,
    input  logic [LBM_NUM_STAGES-1:0]    dout_ready,
    output logic                         sel_err,
`ifdef DEMUX11_AUTOSEQ_EN
    output logic                         seq_wrap,
`endif
    output stage_sel_t                   dest_q,
    output logic [CNT_W-1:0]             xfer_cnt
);

    localparam int NUM_DEST = LBM_NUM_STAGES;

    dist_state_t                  state_q;
    logic signed [DATA_WIDTH-1:0] dout_q;
    stage_sel_t                   dest_r_q;
    logic                         sel_err_q;
    logic [CNT_W-1:0]             xfer_q;

    logic       hold;
    logic       deliver;
    logic       rdy;
    logic       accept;
    stage_sel_t dest_d;
    logic       sel_bad;

    assign hold    = (state_q == DIST_HOLD);
    assign deliver = hold & dout_ready[dest_r_q];
    assign rdy     = (state_q == DIST_IDLE) | deliver;
    assign accept  = din_valid & rdy;

`ifdef DEMUX11_AUTOSEQ_EN
    stage_sel_t seq_dest;

    lbm_dest_seq u_seq (
        .Clk       (Clk),
        .Reset     (Reset),
        .adv_i     (accept),
        .wrap_ev_i (deliver & (dest_r_q == stage_sel_t'(NUM_DEST - 1))),
        .dest_o    (seq_dest),
        .wrap_o    (seq_wrap)
    );

    assign dest_d  = seq_dest;
    assign sel_bad = 1'b0;
`else
    assign dest_d  = sel_legal(select) ? select : '0;
    assign sel_bad = ~sel_legal(select);
`endif

    // Distributor FSM: capture on accept, hold until the dest acks.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= DIST_IDLE;
            dout_q    <= '0;
            dest_r_q  <= '0;
            sel_err_q <= 1'b0;
            xfer_q    <= '0;
        end else begin
            sel_err_q <= 1'b0;
            if (deliver)
                xfer_q <= xfer_q + CNT_W'(1);
            if (accept) begin
                dout_q    <= Din;
                dest_r_q  <= dest_d;
                sel_err_q <= sel_bad;
                state_q   <= DIST_HOLD;
            end else if (deliver) begin
                state_q   <= DIST_IDLE;
            end
        end
    end

    assign din_ready  = ~Reset & rdy;
    assign dout_valid = hold ? (NUM_DEST'(1) << dest_r_q) : '0;
    assign Dout       = dout_q;
    assign dest_q     = dest_r_q;
    assign sel_err    = sel_err_q;
    assign xfer_cnt   = xfer_q;

endmodule
